audio_mix_scheduler: RTL

//  Time-division mix controller ahead of the left/right sigma-delta DACs. One

---
 rtl/audio_pkg.sv | 29 ++
 rtl/audio_gain_mac.sv | 48 ++++
 rtl/audio_mix_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio mix scheduler: pan encodings,
// configuration reset value and the frame sequencing FSM states.
package audio_pkg;

  typedef enum logic [1:0] {
    PAN_OFF  = 2'b00,
    PAN_L    = 2'b01,
    PAN_R    = 2'b10,
    PAN_BOTH = 2'b11
  } pan_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LATCH = 2'b01,
    ACCUM = 2'b10,
    SAT   = 2'b11
  } state_e;

  localparam logic [7:0] CFG_RESET = 8'h3F;

  function automatic logic [3:0] cfg_gain(input logic [7:0] cfg);
    return cfg[3:0];
  endfunction

  function automatic pan_e cfg_pan(input logic [7:0] cfg);
    return pan_e'(cfg[5:4]);
  endfunction

endpackage

// File: rtl/audio_gain_mac.sv
// Shared combinational gain stage: term = (s*(g+1))>>4, added to the left
// and/or right accumulator according to the channel pan setting.
module audio_gain_mac
  import audio_pkg::*;
#(
  parameter int SW = 8,
  parameter int AW = 11
) (
  input  logic [SW-1:0] sample_i,
  input  logic [7:0]    cfg_i,
  input  logic [AW-1:0] acc_l_i,
  input  logic [AW-1:0] acc_r_i,
  output logic [AW-1:0] acc_l_o,
  output logic [AW-1:0] acc_r_o
);

  localparam int PW = SW + 4;

  logic [PW-1:0] gain_s;
  logic [PW-1:0] prod_s;
  logic [SW-1:0] term_s;

  // Scale the sample and steer the term into the selected accumulators
  always_comb begin
    gain_s  = PW'(cfg_gain(cfg_i)) + PW'(1);
    prod_s  = PW'(sample_i) * gain_s;
    term_s  = prod_s[PW-1:4];
    acc_l_o = acc_l_i;
    acc_r_o = acc_r_i;
    case (cfg_pan(cfg_i))
      PAN_L: begin
        acc_l_o = acc_l_i + AW'(term_s);
      end
      PAN_R: begin
        acc_r_o = acc_r_i + AW'(term_s);
      end
      PAN_BOTH: begin
        acc_l_o = acc_l_i + AW'(term_s);
        acc_r_o = acc_r_i + AW'(term_s);
      end
      default: begin
        acc_l_o = acc_l_i;
        acc_r_o = acc_r_i;
      end
    endcase
  end

endmodule

// File: rtl/audio_mix_scheduler.sv
// Time-division mixer: once per frame, sequences one shared gain/pan MAC over
// NCH sources and delivers saturated left/right samples to the DACs.
module audio_mix_scheduler
  import audio_pkg::*;
#(
  parameter int NCH       = 5,
  parameter int SW        = 8,
  parameter int OW        = 9,
  parameter int FRAME_DIV = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*SW-1:0] ch_sample,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  output logic [OW-1:0]     out_left,
  output logic [OW-1:0]     out_right,
  output logic              out_valid,
  output logic              busy
);

  localparam int AW = SW + 3;
  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int IW = 3;
  localparam logic [AW-1:0] OMAX = AW'((2 ** OW) - 1);

  function automatic logic [OW-1:0] sat_clamp(input logic [AW-1:0] acc);
    if (acc > OMAX) begin
      sat_clamp = {OW{1'b1}};
    end else begin
      sat_clamp = acc[OW-1:0];
    end
  endfunction

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [AW-1:0]            acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [NCH-1:0][SW-1:0]   samp_q, samp_d;
  logic [NCH-1:0][7:0]      shadow_q, shadow_d, active_q, active_d;
  logic [OW-1:0]            out_left_q, out_left_d, out_right_q, out_right_d;
  logic                     out_valid_q, out_valid_d, busy_q, busy_d;
  logic                     tick_s;
  logic [SW-1:0]            mac_samp_s;
  logic [7:0]               mac_cfg_s;
  logic [AW-1:0]            mac_l_s, mac_r_s;

  // Select the channel currently being accumulated; out-of-range idx reads zero
  always_comb begin
    mac_samp_s = '0;
    mac_cfg_s  = 8'h00;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == IW'(k)) begin
        mac_samp_s = samp_q[k];
        mac_cfg_s  = active_q[k];
      end else begin
        mac_samp_s = mac_samp_s;
        mac_cfg_s  = mac_cfg_s;
      end
    end
  end

  audio_gain_mac #(.SW(SW), .AW(AW)) u_mac (
    .sample_i (mac_samp_s),
    .cfg_i    (mac_cfg_s),
    .acc_l_i  (acc_l_q),
    .acc_r_i  (acc_r_q),
    .acc_l_o  (mac_l_s),
    .acc_r_o  (mac_r_s)
  );

  assign tick_s = (cnt_q == CW'(FRAME_DIV - 1));

  // Frame counter, config shadow writes and frame sequencing next state
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    samp_d      = samp_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = 1'b0;

    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    for (int k = 0; k < NCH; k++) begin
      if (cfg_we && (cfg_addr == IW'(k))) begin
        shadow_d[k] = cfg_wdata;
      end else begin
        shadow_d[k] = shadow_q[k];
      end
    end

    case (state_q)
      IDLE: begin
        if (tick_s) begin
          state_d = LATCH;
        end else begin
          state_d = IDLE;
        end
      end
      LATCH: begin
        samp_d   = ch_sample;
        active_d = shadow_q;
        acc_l_d  = '0;
        acc_r_d  = '0;
        idx_d    = '0;
        state_d  = ACCUM;
      end
      ACCUM: begin
        acc_l_d = mac_l_s;
        acc_r_d = mac_r_s;
        idx_d   = idx_q + IW'(1);
        // Last channel: clamp the final sums so they are presented during SAT
        if (idx_q == IW'(NCH - 1)) begin
          state_d     = SAT;
          out_left_d  = sat_clamp(mac_l_s);
          out_right_d = sat_clamp(mac_r_s);
          out_valid_d = 1'b1;
        end else begin
          state_d = ACCUM;
        end
      end
      SAT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      samp_q      <= '0;
      shadow_q    <= {NCH{CFG_RESET}};
      active_q    <= {NCH{CFG_RESET}};
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      samp_q      <= samp_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
